// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first.
//   One full-subtractor cell handles a single bit pair plus the registered
//   borrow in each SHIFT cycle. Its difference bits collect in an accumulator
//   that becomes the parallel result when the operation finishes.
//   A start/done handshake connects the block to the parent datapath.
//
//   Optional feature macro: SERIAL_SUB_OVF_EN
//     When it is defined, the block adds the ovf port, which flags a signed
//     overflow. When it is undefined, the port and its logic are absent.
//
// Parameters
//   WIDTH   operand/result width in bits (2..32)
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      request; sampled only in IDLE
//   a        in   WIDTH  minuend, captured when start is accepted
//   b        in   WIDTH  subtrahend, captured when start is accepted
//   busy     out  1      high while an operation is in SHIFT or DONE
//   done     out  1      one-cycle pulse; diff/borrow/ovf are valid
//   diff     out  WIDTH  a - b modulo 2^WIDTH
//   borrow   out  1      final borrow-out (a < b unsigned)
//   ovf      out  1      signed overflow (SERIAL_SUB_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             br_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;

  // Full-subtractor cell for the current bit pair.
  logic             cell_a;
  logic             cell_b;
  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] acc_next;

  assign cell_a  = a_sr_reg[0];
  assign cell_b  = b_sr_reg[0];
  assign cell_d  = cell_a ^ cell_b ^ br_reg;
  assign cell_bo = (~cell_a & cell_b) | (~(cell_a ^ cell_b) & br_reg);

  // Difference bits enter at the MSB, so after WIDTH shifts bit 0 holds the
  // LSB of the result. No separate reordering step is needed.
  assign acc_next = {cell_d, acc_reg[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
  // The operand shift registers lose their MSBs while shifting, so the sign
  // bits are kept separately for the overflow decision.
  logic a_msb_reg;
  logic b_msb_reg;
  logic ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && start) begin
        a_msb_reg <= a[WIDTH-1];
        b_msb_reg <= b[WIDTH-1];
      end
      // cell_d on the last shift is the MSB of the final difference.
      if (state_reg == ST_SHIFT && cnt_reg == LAST_CNT) begin
        ovf_reg <= (a_msb_reg != b_msb_reg) && (cell_d != a_msb_reg);
      end
    end
  end

  assign ovf = ovf_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      acc_reg    <= '0;
      br_reg     <= 1'b0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b;
            acc_reg   <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sr_reg <= {1'b0, a_sr_reg[WIDTH-1:1]};
          b_sr_reg <= {1'b0, b_sr_reg[WIDTH-1:1]};
          acc_reg  <= acc_next;
          br_reg   <= cell_bo;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            diff_reg   <= acc_next;
            borrow_reg <= cell_bo;
            done_reg   <= 1'b1;
            state_reg  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // A start seen here is ignored. It is sampled again in IDLE.
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign diff   = diff_reg;
  assign borrow = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks;
  int errors;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operands.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned r;
    r = (int'(x) - int'(y) + 256) % 256;
    return r[W-1:0];
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return int'(x) < int'(y);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx;
    int sy;
    int r;
    sx = (int'(x) >= 128) ? int'(x) - 256 : int'(x);
    sy = (int'(y) >= 128) ? int'(y) - 256 : int'(y);
    r  = sx - sy;
    return (r > 127) || (r < -128);
  endfunction

  // Issues one request from IDLE, changes the operands right after
  // acceptance, and counts cycles until the done pulse (at most 40).
  // lat is the number of cycles after the accepting edge, or -1 on timeout.
  task automatic issue_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                          output int lat, output int busy_cycles);
    @(negedge clk);
    start = 1'b1;
    a     = ai;
    b     = bi;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    lat         = -1;
    busy_cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b diff=%h borrow=%b required 0/0/00/0",
               busy, done, diff, borrow);
    end
`ifdef SERIAL_SUB_OVF_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %b required 0", ovf);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("test_reset: busy=%b done=%b diff=%h borrow=%b", busy, done, diff, borrow);
  endtask

  task automatic test_directed();
    logic [W-1:0] va [4] = '{8'h05, 8'h03, 8'h00, 8'hA5};
    logic [W-1:0] vb [4] = '{8'h03, 8'h05, 8'hFF, 8'hA5};
    logic [W-1:0] exp_d [4] = '{8'h02, 8'hFE, 8'h01, 8'h00};
    logic         exp_b [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat;
    int bc;
    for (int i = 0; i < 4; i++) begin
      issue_op(va[i], vb[i], lat, bc);
      checks++;
      if (lat != 9) begin
        errors++;
        $display("FAIL directed_latency op%0d got %0d required 9", i, lat);
      end
      checks++;
      if (bc != 9) begin
        errors++;
        $display("FAIL directed_busy_cycles op%0d got %0d required 9", i, bc);
      end
      checks++;
      if (diff !== exp_d[i] || borrow !== exp_b[i]) begin
        errors++;
        $display("FAIL directed_result a=%h b=%h got diff=%h borrow=%b required diff=%h borrow=%b",
                 va[i], vb[i], diff, borrow, exp_d[i], exp_b[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL directed_done_width op%0d got done=%b busy=%b required 0/0", i, done, busy);
      end
      $display("test_directed: a=%h b=%h diff=%h borrow=%b lat=%0d busy_cycles=%0d",
               va[i], vb[i], diff, borrow, lat, bc);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);  // third shift cycle
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h00;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    for (int i = 4; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 9 || diff !== 8'h0F || borrow !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start got lat=%0d diff=%h borrow=%b required lat=9 diff=0f borrow=0",
               lat, diff, borrow);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || diff !== 8'h0F) begin
      errors++;
      $display("FAIL ignore_no_queue got busy=%b diff=%h required busy=0 diff=0f", busy, diff);
    end
    $display("test_ignore_start: diff=%h borrow=%b lat=%0d", diff, borrow, lat);
  endtask

  task automatic test_reset_abort();
    int lat;
    int bc;
    int done_seen;
    @(negedge clk);
    start = 1'b1;
    a     = 8'h33;
    b     = 8'h11;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);  // fourth shift cycle
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || diff !== '0 || borrow !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got busy=%b diff=%h borrow=%b done=%b required 0/00/0/0",
               busy, diff, borrow, done);
    end
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (i == 2) rst_n = 1'b1;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d done cycles required 0", done_seen);
    end
    issue_op(8'h09, 8'h04, lat, bc);
    checks++;
    if (lat != 9 || diff !== 8'h05 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL abort_recover got lat=%0d diff=%h borrow=%b required lat=9 diff=05 borrow=0",
               lat, diff, borrow);
    end
    $display("test_reset_abort: diff=%h borrow=%b lat=%0d", diff, borrow, lat);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    int lat0;
    int lat1;
    a0 = W'($urandom);
    b0 = W'($urandom);
    a1 = W'($urandom);
    b1 = W'($urandom);
    @(negedge clk);
    start = 1'b1;
    a     = a0;
    b     = b0;
    @(posedge clk);
    #1;
    a = a1;  // start stays high; these are captured on re-acceptance
    b = b1;
    lat0 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat0 = i;
        break;
      end
    end
    checks++;
    if (lat0 != 9 || diff !== ref_diff(a0, b0) || borrow !== ref_borrow(a0, b0)) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d diff=%h borrow=%b required lat=9 diff=%h borrow=%b",
               lat0, diff, borrow, ref_diff(a0, b0), ref_borrow(a0, b0));
    end
    lat1 = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat1 = i;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat1 != 10 || diff !== ref_diff(a1, b1) || borrow !== ref_borrow(a1, b1)) begin
      errors++;
      $display("FAIL b2b_second got spacing=%0d diff=%h borrow=%b required spacing=10 diff=%h borrow=%b",
               lat1, diff, borrow, ref_diff(a1, b1), ref_borrow(a1, b1));
    end
    // Wait out a possible third op that was accepted before start dropped.
    repeat (14) @(negedge clk);
    $display("test_back_to_back: op0 %h-%h lat=%0d op1 %h-%h spacing=%0d",
             a0, b0, lat0, a1, b1, lat1);
  endtask

  task automatic test_random();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int lat;
    int bc;
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n == 0) rb = ra;
      issue_op(ra, rb, lat, bc);
      checks++;
      if (lat != 9 || diff !== ref_diff(ra, rb) || borrow !== ref_borrow(ra, rb)) begin
        errors++;
        $display("FAIL random_op a=%h b=%h got lat=%0d diff=%h borrow=%b required lat=9 diff=%h borrow=%b",
                 ra, rb, lat, diff, borrow, ref_diff(ra, rb), ref_borrow(ra, rb));
      end
`ifdef SERIAL_SUB_OVF_EN
      checks++;
      if (ovf !== ref_ovf(ra, rb)) begin
        errors++;
        $display("FAIL random_ovf a=%h b=%h got %b required %b", ra, rb, ovf, ref_ovf(ra, rb));
      end
`endif
      // Results must hold while the block is idle.
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (diff !== ref_diff(ra, rb)) begin
        errors++;
        $display("FAIL random_hold a=%h b=%h got diff=%h required %h", ra, rb, diff, ref_diff(ra, rb));
      end
      $display("test_random: a=%h b=%h diff=%h borrow=%b", ra, rb, diff, borrow);
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int lat;
    int bc;
    issue_op(8'h80, 8'h01, lat, bc);
    checks++;
    if (diff !== 8'h7F || ovf !== 1'b1 || borrow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_set got diff=%h ovf=%b borrow=%b required 7f/1/0", diff, ovf, borrow);
    end
    $display("test_ovf: a=80 b=01 diff=%h ovf=%b", diff, ovf);
    issue_op(8'h05, 8'h03, lat, bc);
    checks++;
    if (diff !== 8'h02 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got diff=%h ovf=%b required 02/0", diff, ovf);
    end
    $display("test_ovf: a=05 b=03 diff=%h ovf=%b", diff, ovf);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
